// File: rtl/dijkstra_seq.sv
// Multi-cycle single-source shortest-path engine: INIT, then NUMVALS x (SELECT + NUMVALS RELAX cycles), then FIN.
// Optional DIJKSTRA_EARLY_EXIT_EN: leave for FIN as soon as SELECT finds no reachable unvisited node.
module dijkstra_seq #(
    parameter int NUMVALS = 6,
    parameter int SIZE    = 32,
    parameter int INT_MAX = 10000,
    parameter int IDXW    = (NUMVALS > 1) ? $clog2(NUMVALS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [IDXW-1:0]                 src,
    input  logic [NUMVALS*NUMVALS*SIZE-1:0] g_input,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [NUMVALS*SIZE-1:0]         o,
    output logic [NUMVALS*IDXW-1:0]         parent_o,
    output logic [NUMVALS-1:0]              reach_o
);

    localparam int GW  = NUMVALS * NUMVALS * SIZE;
    localparam int GIW = $clog2(GW);
    localparam logic [SIZE-1:0] INF   = SIZE'(INT_MAX);
    localparam logic [SIZE:0]   INF_X = (SIZE + 1)'(INT_MAX);
    localparam logic [IDXW-1:0] LAST  = IDXW'(NUMVALS - 1);

    typedef enum logic [2:0] {IDLE, INIT, SELECT, RELAX, FIN} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       g_q, g_d;
    logic [IDXW-1:0]     src_q, src_d;
    logic [SIZE-1:0]     dist_q [NUMVALS];
    logic [SIZE-1:0]     dist_d [NUMVALS];
    logic [IDXW-1:0]     par_q  [NUMVALS];
    logic [IDXW-1:0]     par_d  [NUMVALS];
    logic [NUMVALS-1:0]  vis_q, vis_d;
    logic [IDXW-1:0]     u_q, u_d, v_q, v_d, iter_q, iter_d;
    logic                empty_q, empty_d, err_q, err_d;
    logic [NUMVALS*SIZE-1:0] o_q;
    logic [NUMVALS*IDXW-1:0] par_o_q;
    logic [NUMVALS-1:0]      reach_q;

    logic                sel_found;
    logic [IDXW-1:0]     sel_idx;
    logic [SIZE-1:0]     best;
    logic [GIW-1:0]      gbase;
    logic [SIZE-1:0]     w;
    logic [SIZE:0]       cand;
    logic                upd;

    // Strict < keeps the lowest index among equal minimum distances.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best      = INF;
        for (int unsigned i = 0; i < NUMVALS; i++) begin
            if (!vis_q[i] && dist_q[i] < best) begin
                best      = dist_q[i];
                sel_idx   = IDXW'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        gbase = GIW'((int'(u_q) * NUMVALS + int'(v_q)) * SIZE);
        w     = g_q[gbase +: SIZE];
        cand  = {1'b0, dist_q[u_q]} + {1'b0, w};
        upd   = !empty_q && (v_q != u_q) && !vis_q[v_q] && (w != '0) &&
                (cand < {1'b0, dist_q[v_q]}) && (cand < INF_X);
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        src_d   = src_q;
        dist_d  = dist_q;
        par_d   = par_q;
        vis_d   = vis_q;
        u_d     = u_q;
        v_d     = v_q;
        iter_d  = iter_q;
        empty_d = empty_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    g_d     = g_input;
                    src_d   = src;
                    state_d = INIT;
                end
            end
            INIT: begin
                for (int unsigned i = 0; i < NUMVALS; i++) begin
                    dist_d[i] = INF;
                    par_d[i]  = IDXW'(i);
                end
                vis_d  = '0;
                iter_d = '0;
                v_d    = '0;
                if (int'(src_q) >= NUMVALS) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    err_d         = 1'b0;
                    dist_d[src_q] = '0;
                    state_d       = SELECT;
                end
            end
            SELECT: begin
                v_d     = '0;
                empty_d = !sel_found;
                if (sel_found) begin
                    u_d            = sel_idx;
                    vis_d[sel_idx] = 1'b1;
                end
                state_d = RELAX;
`ifdef DIJKSTRA_EARLY_EXIT_EN
                if (!sel_found) state_d = FIN;
`else
`endif
            end
            RELAX: begin
                if (upd) begin
                    dist_d[v_q] = cand[SIZE-1:0];
                    par_d[v_q]  = u_q;
                end
                if (v_q == LAST) begin
                    v_d = '0;
                    if (iter_q == LAST) begin
                        state_d = FIN;
                    end else begin
                        iter_d  = iter_q + 1'b1;
                        state_d = SELECT;
                    end
                end else begin
                    v_d = v_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            src_q   <= '0;
            dist_q  <= '{default: '0};
            par_q   <= '{default: '0};
            vis_q   <= '0;
            u_q     <= '0;
            v_q     <= '0;
            iter_q  <= '0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
            o_q     <= '0;
            par_o_q <= '0;
            reach_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            src_q   <= src_d;
            dist_q  <= dist_d;
            par_q   <= par_d;
            vis_q   <= vis_d;
            u_q     <= u_d;
            v_q     <= v_d;
            iter_q  <= iter_d;
            empty_q <= empty_d;
            err_q   <= err_d;
            // Capture from next-state so the final RELAX update lands in the FIN-cycle outputs.
            if (state_d == FIN) begin
                for (int unsigned i = 0; i < NUMVALS; i++) begin
                    o_q[i*SIZE +: SIZE]     <= dist_d[i];
                    par_o_q[i*IDXW +: IDXW] <= par_d[i];
                    reach_q[i]              <= (dist_d[i] < INF);
                end
            end
        end
    end

    assign busy     = (state_q == INIT) || (state_q == SELECT) || (state_q == RELAX);
    assign done     = (state_q == FIN);
    assign err      = err_q;
    assign o        = o_q;
    assign parent_o = par_o_q;
    assign reach_o  = reach_q;

endmodule

// File: tb/tb_dijkstra_seq.sv
// Randomized and directed bench for dijkstra_seq against a plain-array Dijkstra reference.
module tb_dijkstra_seq;

    localparam int N    = 6;
    localparam int SZ   = 32;
    localparam int INF  = 10000;
    localparam int IW   = 3;
    localparam int GW   = N * N * SZ;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [IW-1:0]     src = '0;
    logic [GW-1:0]     g_input = '0;
    logic              busy, done, err;
    logic [N*SZ-1:0]   o;
    logic [N*IW-1:0]   parent_o;
    logic [N-1:0]      reach_o;

    int n_checks = 0;
    int n_errors = 0;

    longint m_dist [N];
    int     m_par  [N];
    int     m_k;

    dijkstra_seq #(.NUMVALS(N), .SIZE(SZ), .INT_MAX(INF), .IDXW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .g_input(g_input),
        .busy(busy), .done(done), .err(err), .o(o), .parent_o(parent_o), .reach_o(reach_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic void model(input logic [GW-1:0] g, input int s);
        bit     vis [N];
        int     u;
        longint best, w, cand;
        m_k = 0;
        for (int i = 0; i < N; i++) begin
            m_dist[i] = INF;
            m_par[i]  = i;
            vis[i]    = 0;
        end
        if (s >= N) return;
        m_dist[s] = 0;
        for (int it = 0; it < N; it++) begin
            u = -1;
            best = INF;
            for (int i = 0; i < N; i++)
                if (!vis[i] && m_dist[i] < best) begin
                    best = m_dist[i];
                    u = i;
                end
            if (u < 0) break;
            vis[u] = 1;
            m_k++;
            for (int v = 0; v < N; v++) begin
                w = longint'(g[(u*N+v)*SZ +: SZ]);
                cand = m_dist[u] + w;
                if (w != 0 && !vis[v] && cand < m_dist[v] && cand < INF) begin
                    m_dist[v] = cand;
                    m_par[v]  = u;
                end
            end
        end
    endfunction

    task automatic set_edge(input int u, input int v, input int wt);
        g_input[(u*N+v)*SZ +: SZ] = SZ'(wt);
    endtask

    task automatic run_case(input int s, input bit poke);
        logic [GW-1:0] gm;
        int cycles, exp_len;
        bit seen;
        gm = g_input;
        model(gm, s);
        if (s >= N) exp_len = 1;
`ifdef DIJKSTRA_EARLY_EXIT_EN
        else if (m_k < N) exp_len = 1 + m_k * (N + 1) + 1;
`endif
        else exp_len = 1 + N * (N + 1);
        @(negedge clk);
        src   = IW'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < N*N; j++) set_edge(j / N, j % N, int'($urandom_range(0, 30)));
        cycles = 0;
        seen   = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) cycles++;
            if (poke) start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("busy_len", cycles, exp_len);
        check("busy_at_done", busy, 0);
        check("err", err, (s >= N) ? 1 : 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("dist[%0d]", i), o[i*SZ +: SZ], m_dist[i]);
            check($sformatf("parent[%0d]", i), parent_o[i*IW +: IW], m_par[i]);
            check($sformatf("reach[%0d]", i), reach_o[i], (m_dist[i] < INF) ? 1 : 0);
        end
        @(negedge clk);
        check("done_pulse", done, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("hold_dist[%0d]", i), o[i*SZ +: SZ], m_dist[i]);
    endtask

    task automatic chain_graph();
        g_input = '0;
        set_edge(0, 1, 4);
        set_edge(1, 2, 3);
        set_edge(2, 3, 2);
        set_edge(3, 4, 1);
        set_edge(4, 5, 5);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_o", (o == '0) ? 1 : 0, 1);
        @(negedge clk);
        rst = 1'b1;

        chain_graph();
        run_case(0, 0);
        check("chain_o", o, {32'd15, 32'd10, 32'd9, 32'd7, 32'd4, 32'd0});
        check("chain_par", parent_o, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0});
        check("chain_reach", reach_o, 6'b111111);

        chain_graph();
        set_edge(0, 5, 14);
        run_case(0, 0);
        check("direct_d5", o[5*SZ +: SZ], 14);
        check("direct_p5", parent_o[5*IW +: IW], 0);

        chain_graph();
        set_edge(0, 5, 15);
        run_case(0, 0);
        check("tie_p5", parent_o[5*IW +: IW], 0);

        chain_graph();
        run_case(3, 0);
        check("src3_reach", reach_o, 6'b111000);
        check("src3_d5", o[5*SZ +: SZ], 6);

        run_case(7, 0);
        check("err_reach", reach_o, 0);
        check("err_d0", o[0 +: SZ], INF);

        g_input = '0;
        set_edge(0, 1, 9999);
        set_edge(1, 2, 5);
        run_case(0, 0);
        check("ovf_d2", o[2*SZ +: SZ], INF);
        check("ovf_r2", reach_o[2], 0);

        chain_graph();
        @(negedge clk);
        src = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_o", (o == '0) ? 1 : 0, 1);
        check("abort_par", (parent_o == '0) ? 1 : 0, 1);
        check("abort_reach", reach_o, 0);
        @(negedge clk);
        rst = 1'b1;
        chain_graph();
        run_case(0, 1);

        for (int t = 0; t < 30; t++) begin
            g_input = '0;
            for (int j = 0; j < N*N; j++) begin
                if ($urandom_range(0, 99) < 40) begin
                    if ($urandom_range(0, 9) == 0) set_edge(j / N, j % N, int'($urandom_range(9990, 9999)));
                    else set_edge(j / N, j % N, int'($urandom_range(1, 50)));
                end
            end
            run_case(($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5)),
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dijkstra_seq.md
Name: dijkstra_seq

Overview:
Multi-cycle, parametrised single-source shortest-path engine for the garbled-circuit benchmark set. It is the sequential successor to the combinational Dijkstra block. The block latches an NxN adjacency matrix and a selectable source node on a start handshake. It then iterates select-min/relax over a fixed number of cycles and returns per-node distance, parent and reachability. The fixed latency makes it suitable for cycle-counted sequential garbling flows.

Parameters:
NUMVALS, 6, number of graph nodes (N), >= 2
SIZE, 32, bit width of edge weights and distances
INT_MAX, 10000, infinity marker; must satisfy INT_MAX < 2^SIZE
IDXW, $clog2(NUMVALS) (min 1), width of node indices

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request; sampled only in IDLE
src  input  IDXW  source node index, latched with start
g_input  input  NUMVALS*NUMVALS*SIZE  adjacency matrix; weight u->v at bits (u*NUMVALS+v)*SIZE +: SIZE; 0 = no edge
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse; results valid from this cycle
err  output  1  src >= NUMVALS on last start; valid with done
o  output  NUMVALS*SIZE  dist[i] at i*SIZE +: SIZE
parent_o  output  NUMVALS*IDXW  parent[i] at i*IDXW +: IDXW
reach_o  output  NUMVALS  bit i = 1 if dist[i] < INT_MAX

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, err=0; o, parent_o, reach_o = 0; internal dist/visited cleared. Reset mid-run aborts the run; no done is issued.
- FSM states: IDLE, INIT, SELECT, RELAX, FIN.
- IDLE: on start=1, latch g_input and src into internal registers, then go to INIT. The input bus is don't-care after acceptance. start outside IDLE is ignored (no queueing).
- INIT (1 cycle): dist[i]=INT_MAX, parent[i]=i, visited[i]=0; dist[src]=0. If src >= NUMVALS, set err=1 and go to FIN without setting any dist to 0.
- Iterations: exactly NUMVALS of them; each is SELECT followed by RELAX.
- SELECT (1 cycle): u = lowest-index unvisited node with the minimum dist < INT_MAX; set visited[u]=1. If no such node exists, flag the iteration empty.
- RELAX (NUMVALS cycles, v = 0..N-1, one per cycle): for edge weight w, update when all of these hold: iteration not empty, v != u, visited[v]=0, w != 0, and cand = dist[u]+w (SIZE+1 bits) < dist[v] and cand < INT_MAX. The update sets dist[v]=cand[SIZE-1:0] and parent[v]=u.
- Ties: a strict < comparison everywhere, so the earlier parent is kept.
- Latency: busy is high for exactly 1 + N*(N+1) cycles (INIT + iterations), i.e. 43 for N=6. FIN follows for 1 cycle: done=1, busy=0, outputs registered from internal state, then back to IDLE.
- On err, FIN follows INIT directly (busy high 1 cycle). Outputs: o all INT_MAX, parent_o[i]=i, reach_o=0.
- Outputs hold their values until the next FIN or reset. start in the FIN cycle is ignored.
- Unreachable node: dist=INT_MAX, parent=itself, reach bit 0.

Optional Feature:
DIJKSTRA_EARLY_EXIT_EN:
- Defined: when SELECT finds no eligible node, go directly to FIN, skipping the RELAX and remaining iterations. busy length then becomes 1 + k*(N+1) + 1, where k = number of non-empty iterations. Results are identical to the non-early-exit build.
- Undefined: latency is always 1 + N*(N+1); empty iterations run RELAX with no updates.

Test Plan:
- N=6, src=0, chain 0->1=4, 1->2=3, 2->3=2, 3->4=1, 4->5=5, all else 0 -> after busy=43 cycles, done=1; o={0,4,7,9,10,15}; parent_o={0,0,1,2,3,4}; reach_o=6'b111111.
- Same graph plus direct edge 0->5=14; src=0 -> dist[5]=14, parent[5]=0. With 0->5=15 (tie) -> parent[5]=0 kept (first found, strict <).
- src=3 on the chain graph -> o={10000,10000,10000,0,1,6}; reach_o=6'b111000. With DIJKSTRA_EARLY_EXIT_EN, busy=1+3*7+1=23 cycles; without it, 43.
- src=7 (N=6, IDXW=3) -> err=1, done after 1 busy cycle, o all 10000, reach_o=0.
- Edge 0->1=9999 and 1->2=5 -> cand 10004 >= INT_MAX, so dist[2]=10000 and reach_o[2]=0.
- Assert rst=0 at cycle 20 of a run -> busy, done, o immediately 0. A new start after release completes normally with the correct result. start pulsed while busy -> no effect on result or latency.
